// File: rtl/alu_pkg.sv
// Shared opcode enumeration, width constants and result bundle for the ALU.
// Optional multiply/divide support is selected with the ALU_MULDIV_EN macro.
package alu_pkg;

  localparam int OPND_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_MOD  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_EQ   = 4'h7,
    OP_LAND = 4'h8,
    OP_LOR  = 4'h9,
    OP_SHR  = 4'hA,
    OP_SHL  = 4'hB,
    OP_XOR  = 4'hC,
    OP_NOT  = 4'hD,
    OP_CAT  = 4'hE,
    OP_RSVD = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic [RES_W-1:0] out;
    logic             overflow;
    logic             carry;
  } alu_res_t;

  localparam alu_res_t ALU_RES_ZERO = '{out: '0, overflow: 1'b0, carry: 1'b0};

  function automatic logic [RES_W-1:0] zext8(input logic [OPND_W-1:0] v);
    return {{(RES_W-OPND_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operands and opcode in, result and flags out.
// Opcodes 2/3/4 only get hardware when ALU_MULDIV_EN is defined.
module alu_core
  import alu_pkg::*;
(
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  input  logic [3:0]        operator,
  output logic [RES_W-1:0]  out,
  output logic              overflow,
  output logic              carry
);

  // Signed overflow views of the 8-bit sum and difference.
  function automatic logic add_ovf(input logic [OPND_W-1:0] a, input logic [OPND_W-1:0] b,
                                   input logic [OPND_W-1:0] s);
    return (a[OPND_W-1] == b[OPND_W-1]) && (s[OPND_W-1] != a[OPND_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic [OPND_W-1:0] a, input logic [OPND_W-1:0] b,
                                   input logic [OPND_W-1:0] d);
    return (a[OPND_W-1] != b[OPND_W-1]) && (d[OPND_W-1] != a[OPND_W-1]);
  endfunction

  function automatic logic [RES_W-1:0] flag_res(input logic f);
    return {{(RES_W-1){1'b0}}, f};
  endfunction

  alu_op_e            op;
  logic [OPND_W:0]    sum_w;
  logic [OPND_W:0]    diff_w;
  logic [RES_W-1:0]   ext_a;
  logic [RES_W-1:0]   shr_w;
  logic [RES_W-1:0]   shl_w;
  logic               a_true;
  logic               b_true;
  alu_res_t           res;

  assign op     = alu_op_e'(operator);
  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} - {1'b0, B};
  assign ext_a  = zext8(A);
  // Shifting a 16-bit value by an 8-bit amount already yields 0 for B >= 16.
  assign shr_w  = ext_a >> B;
  assign shl_w  = ext_a << B;
  assign a_true = |A;
  assign b_true = |B;

`ifdef ALU_MULDIV_EN
  logic [RES_W-1:0]  prod_w;
  logic              b_zero;
  logic [OPND_W-1:0] quo_w;
  logic [OPND_W-1:0] rem_w;

  assign prod_w = zext8(A) * zext8(B);
  assign b_zero = ~b_true;
  assign quo_w  = b_zero ? '0 : (A / B);
  assign rem_w  = b_zero ? '0 : (A % B);
`endif

  always_comb begin
    res = ALU_RES_ZERO;
    case (op)
      OP_ADD: begin
        res.out      = zext8(sum_w[OPND_W-1:0]) | {{(RES_W-OPND_W-1){1'b0}}, sum_w[OPND_W], {OPND_W{1'b0}}};
        res.carry    = sum_w[OPND_W];
        res.overflow = add_ovf(A, B, sum_w[OPND_W-1:0]);
      end
      OP_SUB: begin
        res.out      = zext8(diff_w[OPND_W-1:0]);
        res.carry    = diff_w[OPND_W];
        res.overflow = sub_ovf(A, B, diff_w[OPND_W-1:0]);
      end
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        res.out      = prod_w;
        res.overflow = |prod_w[RES_W-1:OPND_W];
      end
      OP_DIV: begin
        res.out      = zext8(quo_w);
        res.overflow = b_zero;
      end
      OP_MOD: begin
        res.out      = zext8(rem_w);
        res.overflow = b_zero;
      end
`endif
      OP_AND:  res.out = zext8(A & B);
      OP_OR:   res.out = zext8(A | B);
      OP_XOR:  res.out = zext8(A ^ B);
      OP_NOT:  res.out = zext8(~A);
      OP_EQ:   res.out = flag_res(A == B);
      OP_LAND: res.out = flag_res(a_true && b_true);
      OP_LOR:  res.out = flag_res(a_true || b_true);
      OP_SHR:  res.out = shr_w;
      OP_SHL:  res.out = shl_w;
      OP_CAT:  res.out = {A, B};
      default: res = ALU_RES_ZERO;
    endcase
  end

  assign out      = res.out;
  assign overflow = res.overflow;
  assign carry    = res.carry;

endmodule

// File: rtl/alu.sv
// ALU top: one-cycle registered wrapper around alu_core; results hold while idle.
// Multiply/divide/modulo are present only when ALU_MULDIV_EN is defined.
module alu
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [OPND_W-1:0]     A,
  input  logic [OPND_W-1:0]     B,
  input  logic [3:0]            operator,
  output logic [RES_W-1:0]      out,
  output logic                  overflow,
  output logic                  carry,
  output logic                  out_valid
);

  logic [RES_W-1:0] core_out;
  logic             core_ovf;
  logic             core_cy;

  alu_core u_core (
    .A        (A),
    .B        (B),
    .operator (operator),
    .out      (core_out),
    .overflow (core_ovf),
    .carry    (core_cy)
  );

  logic [RES_W-1:0] out_d, out_q;
  logic             overflow_d, overflow_q;
  logic             carry_d, carry_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    out_d       = out_q;
    overflow_d  = overflow_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d      = core_out;
      overflow_d = core_ovf;
      carry_d    = core_cy;
    end
  end

  // Output register stage; reset wins over an accepted operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      overflow_q  <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign overflow  = overflow_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios, then random traffic against
// an arithmetic reference model of the opcode rules.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  A, B;
  logic [3:0]  operator;
  logic [15:0] out;
  logic        overflow, carry, out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected architectural state of the outputs.
  int exp_out = 0;
  bit exp_ov  = 0;
  bit exp_cy  = 0;
  bit exp_vld = 0;

  always #5 clk = ~clk;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .operator  (operator),
    .out       (out),
    .overflow  (overflow),
    .carry     (carry),
    .out_valid (out_valid)
  );

  function automatic int sview(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic void ref_op(input int a, input int b, input int op,
                                 output int o, output bit ov, output bit cy);
    int s;
    o = 0; ov = 0; cy = 0;
    case (op)
      0: begin o = a + b; cy = (o > 255); s = sview(a) + sview(b); ov = (s > 127) || (s < -128); end
      1: begin o = (a - b + 256) % 256; cy = (a < b); s = sview(a) - sview(b); ov = (s > 127) || (s < -128); end
`ifdef ALU_MULDIV_EN
      2: begin o = a * b; ov = (o > 255); end
      3: begin if (b == 0) ov = 1; else o = a / b; end
      4: begin if (b == 0) ov = 1; else o = a % b; end
`endif
      5:  o = a & b;
      6:  o = a | b;
      7:  o = (a == b) ? 1 : 0;
      8:  o = (a != 0 && b != 0) ? 1 : 0;
      9:  o = (a != 0 || b != 0) ? 1 : 0;
      10: o = (b >= 16) ? 0 : (a >> b);
      11: o = (b >= 16) ? 0 : ((a << b) % 65536);
      12: o = a ^ b;
      13: o = 255 - a;
      14: o = a * 256 + b;
      default: o = 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"}, int'(out), exp_out);
    chk({tag, ".ovf"}, int'(overflow), int'(exp_ov));
    chk({tag, ".cy"},  int'(carry), int'(exp_cy));
    chk({tag, ".vld"}, int'(out_valid), int'(exp_vld));
  endtask

  // Drive one cycle, update the expected state, then sample #1 after the edge.
  task automatic step(input bit r, input bit v, input int a, input int b, input int op);
    int o; bit ov, cy;
    rst = r; in_valid = v; A = a[7:0]; B = b[7:0]; operator = op[3:0];
    @(posedge clk);
    #1;
    if (r) begin
      exp_out = 0; exp_ov = 0; exp_cy = 0; exp_vld = 0;
    end else if (v) begin
      ref_op(a, b, op, o, ov, cy);
      exp_out = o; exp_ov = ov; exp_cy = cy; exp_vld = 1;
    end else begin
      exp_vld = 0;
    end
  endtask

  task automatic op_chk(input string tag, input int a, input int b, input int op, input int want);
    step(0, 1, a, b, op);
    chk({tag, ".spec"}, int'(out), want);
    check_all(tag);
  endtask

  initial begin
    rst = 1; in_valid = 0; A = 0; B = 0; operator = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_all("reset");

    op_chk("add1", 'h10, 'h20, 0, 'h0030);
    op_chk("add2", 'hFF, 'h01, 0, 'h0100);
    chk("add2.carry_one", int'(carry), 1);
    op_chk("sub1", 'h20, 'h10, 1, 'h0010);
    op_chk("sub_borrow", 'h10, 'h20, 1, 'h00F0);
    op_chk("add_sovf", 'h7F, 'h01, 0, 'h0080);
    chk("add_sovf.flag", int'(overflow), 1);
`ifdef ALU_MULDIV_EN
    op_chk("mul", 'h10, 'h20, 2, 'h0200);
    chk("mul.ovf_one", int'(overflow), 1);
    op_chk("div", 'h20, 'h02, 3, 'h0010);
    op_chk("mod", 'h20, 'h03, 4, 'h0002);
    op_chk("div0", 'h20, 'h00, 3, 'h0000);
    chk("div0.ovf_one", int'(overflow), 1);
`else
    op_chk("mul_off", 'h10, 'h20, 2, 'h0000);
    op_chk("div_off", 'h20, 'h02, 3, 'h0000);
    op_chk("mod_off", 'h20, 'h03, 4, 'h0000);
`endif
    op_chk("and",  'hF0, 'h0F, 5,  'h0000);
    op_chk("or",   'hF0, 'h0F, 6,  'h00FF);
    op_chk("xor",  'hF0, 'h0F, 12, 'h00FF);
    op_chk("not",  'hF0, 'h0F, 13, 'h000F);
    op_chk("cat",  'hF0, 'h0F, 14, 'hF00F);
    op_chk("eq",   'h10, 'h10, 7,  'h0001);
    op_chk("land", 'h10, 'h20, 8,  'h0001);
    op_chk("lor",  'h10, 'h20, 9,  'h0001);
    op_chk("land0",'h10, 'h00, 8,  'h0000);
    op_chk("shr",  'hF0, 'h02, 10, 'h003C);
    op_chk("shl",  'h0F, 'h02, 11, 'h003C);
    op_chk("shl15",'h01, 'h0F, 11, 'h8000);
    op_chk("shl16",'hFF, 'h10, 11, 'h0000);
    op_chk("shr_big",'hFF, 'hC8, 10, 'h0000);
    op_chk("rsvd", 'hAB, 'hCD, 15, 'h0000);

    // Hold behaviour while idle.
    op_chk("pre_hold", 'hF0, 'h0F, 14, 'hF00F);
    step(0, 0, 'h12, 'h34, 0);
    check_all("hold1");
    chk("hold1.kept", int'(out), 'hF00F);
    step(0, 0, 'h55, 'h66, 1);
    check_all("hold2");

    // Reset with a simultaneous operation discards it; next op is accepted.
    step(1, 1, 'hFF, 'h01, 0);
    check_all("rst_vs_valid");
    chk("rst_vs_valid.zero", int'(out), 0);
    op_chk("after_rst", 'h03, 'h04, 0, 'h0007);

    for (int i = 0; i < 400; i++) begin
      int a, b, op;
      bit r, v;
      a  = int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      op = int'($urandom_range(0, 15));
      r  = ($urandom_range(0, 31) == 0);
      v  = ($urandom_range(0, 3) != 0);
      step(r, v, a, b, op);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; all operand and result widths are fixed.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  high = A, B, operator sampled this edge.
REQ-005 A  input  8  operand A, unsigned (signed view for overflow only).
REQ-006 B  input  8  operand B, unsigned (signed view for overflow only).
REQ-007 operator  input  4  opcode, see REQ-010.
REQ-008 out  output  16  registered result.
REQ-009 overflow / carry / out_valid  output  1 each  registered flags; out_valid high one cycle per accepted op.

Function
REQ-010 Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 bitwise AND, 6 bitwise OR, 7 equality, 8 logical AND, 9 logical OR, A shift right, B shift left, C XOR, D NOT, E concat, F reserved.
REQ-011 Latency: exactly 1 cycle. in_valid high at edge N gives results and out_valid=1 after edge N.
REQ-012 in_valid low: out, overflow, carry hold; out_valid=0.
REQ-013 Add: out = zero-extended 9-bit A+B; carry = sum bit 8; overflow = signed 8-bit overflow.
REQ-014 Sub: out = {8'h00, (A-B)[7:0]}; carry = borrow (A<B); overflow = signed 8-bit overflow.
REQ-015 Mul: out = 16-bit unsigned product; overflow = (product > 8'hFF); carry=0.
REQ-016 Div/mod: out = zero-extended A/B or A%B, unsigned. B=0: out=16'h0000, overflow=1.
REQ-017 Bitwise ops (5, 6, C) are 8-bit and zero-extended. NOT (D) = zero-extended ~A, B ignored.
REQ-018 Equality / logical AND / logical OR: out = 16'h0001 if true, else 16'h0000. Operands are true when nonzero.
REQ-019 Shift right: out = {8'h00,A} >> B. Shift left: out = {8'h00,A} << B. Both logical, 16-bit result. B >= 16 gives 0.
REQ-020 Concat: out = {A, B}.
REQ-021 Opcode F: out=0, overflow=0, carry=0; out_valid still asserted.
REQ-022 overflow and carry SHALL be 0 for every opcode except where REQ-013..REQ-016 define them.

Reset
REQ-023 rst high at an edge: out=16'h0000, overflow=0, carry=0, out_valid=0.
REQ-024 rst has priority over in_valid; an operation accepted at a reset edge is discarded.
REQ-025 in_valid at the first edge after rst deasserts is accepted normally.

Configuration
REQ-026 Macro ALU_MULDIV_EN defined: opcodes 2, 3 and 4 behave per REQ-015 and REQ-016.
REQ-027 Macro ALU_MULDIV_EN undefined: no multiplier or divider is synthesized; opcodes 2, 3 and 4 behave as opcode F.

Structure
REQ-028 Shared package alu_pkg SHALL hold the opcode enum (4-bit, names per REQ-010) and the width constants 8 and 16.
REQ-029 The combinational datapath SHALL be one sub-module, alu_core (A, B, operator -> out, overflow, carry); alu registers its outputs.

Verification
REQ-030 Scenario: A=10, B=20, op 0 -> out 0030, carry 0, overflow 0. Then A=FF, B=01, op 0 -> out 0100, carry 1.
REQ-031 Scenario: A=20, B=10, op 1 -> out 0010, carry 0. Then A=10, B=20, op 2 -> out 0200, overflow 1 (macro defined).
REQ-032 Scenario: A=20, B=02, op 3 -> out 0010. A=20, B=03, op 4 -> out 0002. A=20, B=00, op 3 -> out 0000, overflow 1.
REQ-033 Scenario: A=F0, B=0F: op 5 -> 0000; op 6 -> 00FF; op C -> 00FF; op D -> 000F; op E -> F00F.
REQ-034 Scenario: A=10, B=10, op 7 -> 0001. A=10, B=20: op 8 -> 0001, op 9 -> 0001. A=F0, B=02, op A -> 003C. A=0F, B=02, op B -> 003C.
REQ-035 Scenario: rst asserted together with in_valid -> all outputs 0 next cycle. Build without ALU_MULDIV_EN, op 2 -> out 0000.
